// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control sequencer for the multi-cycle MIPS datapath. Each instruction
//   is walked through fetch, decode, execute, memory and writeback states; the
//   datapath mux selects, write enables and the 2-bit alu_op are Moore-decoded
//   from the current state, with ir_write/pc_write in FETCH gated by mem_ready.
//   Memory accesses stall on mem_ready; when WAIT_LIMIT > 0 a watchdog aborts a
//   hung access back to FETCH without any architectural update.
//   Optional feature macro: CTRL_PERF_CNT_EN adds the instr_count and
//   stall_count performance counter ports.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Wait counter only needs to reach WAIT_LIMIT; keep one bit when disabled.
    localparam int WCNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LIMIT_C = WCNT_W'(WAIT_LIMIT);

    // State is held as a plain 4-bit vector so encodings 12-15 are representable
    // and can be recovered from.
    logic [3:0]        state_q;
    logic [3:0]        state_d;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [WCNT_W-1:0] wait_cnt_d;
    logic              in_wait_state;
    logic              mem_wait;
    logic              timeout;

    // Watchdog: count consecutive wait cycles in the memory-access states.
    always_comb begin
        in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
        mem_wait      = in_wait_state && !mem_ready;
        timeout       = (WAIT_LIMIT > 0) && mem_wait && (wait_cnt_q == WAIT_LIMIT_C);
        wait_cnt_d    = '0;
        if ((WAIT_LIMIT > 0) && mem_wait && !timeout) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Next-state and Moore output decode; everything is held at 0 during reset.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        mem_timeout   = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_R:         state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDI_EXEC;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_LW) begin
                        state_d = S_MEM_READ;
                    end else if (opcode == OP_SW) begin
                        state_d = S_MEM_WRITE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_d   = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
            // A timeout only happens with mem_ready low, so the write enables
            // above are already 0 and no architectural state changes.
            if (timeout) begin
                mem_timeout = 1'b1;
                state_d     = S_FETCH;
            end
        end
    end

    // State register and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign state_dbg = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] instr_count_q;
    logic [CNT_WIDTH-1:0] instr_count_d;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic [CNT_WIDTH-1:0] stall_count_d;

    // Retired instructions are entries into FETCH; stalls are non-aborted waits.
    always_comb begin
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH) && !timeout) begin
            instr_count_d = instr_count_q + 1'b1;
        end
        if (mem_wait && !timeout) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Performance counter registers, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
